// File: rtl/output_port_arbiter.sv
// Round-robin, packet-hold arbiter for one crossbar output port.
// Optional stall timeout release is built when ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module output_port_arbiter #(
  parameter int N_IN    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         req,
  input  logic [N_IN-1:0]         flit_valid,
  input  logic [N_IN-1:0]         flit_last,
  input  logic                    out_ready,
  output logic [N_IN-1:0]         grant,
  output logic [$clog2(N_IN)-1:0] grant_idx,
  output logic                    busy,
  output logic                    xfer,
  output logic                    timeout_evt
);

  localparam int IW = $clog2(N_IN);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  state_t         state, state_nx;
  logic [IW-1:0]  ptr, ptr_nx;
  logic [N_IN-1:0] grant_nx;
  logic [IW-1:0]  idx_nx;
  logic           tevt_nx;
  logic           found;
  logic [IW-1:0]  winner;
  logic [IW-1:0]  cand;
  logic           tail;
  logic           stall_hit;

  assign xfer = |(grant & flit_valid) & out_ready;
  assign tail = |(grant & flit_valid & flit_last) & out_ready;
  assign busy = |grant;

  // Search upward from the slot after the last winner, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = ptr;
    for (int k = 1; k <= N_IN; k++) begin
      cand = ptr + IW'(k);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE || xfer) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign stall_hit = (stall_cnt == CW'(TIMEOUT));
`else
  logic unused_timeout;

  assign unused_timeout = |TIMEOUT;
  assign stall_hit      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    idx_nx   = grant_idx;
    ptr_nx   = ptr;
    tevt_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx         = HOLD;
          grant_nx         = '0;
          grant_nx[winner] = 1'b1;
          idx_nx           = winner;
          ptr_nx           = winner;
        end
      end
      HOLD: begin
        if (tail) begin
          state_nx = IDLE;
          grant_nx = '0;
        end else if (stall_hit) begin
          state_nx = IDLE;
          grant_nx = '0;
          tevt_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      ptr         <= '1;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      grant_idx   <= idx_nx;
      ptr         <= ptr_nx;
      timeout_evt <= tevt_nx;
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Randomized and directed checks of output_port_arbiter against
// a packet-level reference model.
`timescale 1ns/1ps
module tb_output_port_arbiter;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] flit_valid;
  logic [15:0] flit_last;
  logic        out_ready;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        busy;
  logic        xfer;
  logic        timeout_evt;

  output_port_arbiter #(
    .N_IN(16),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .flit_valid(flit_valid),
    .flit_last(flit_last),
    .out_ready(out_ready),
    .grant(grant),
    .grant_idx(grant_idx),
    .busy(busy),
    .xfer(xfer),
    .timeout_evt(timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: owning input (-1 = port free), rr pointer, stall count
  int owner = -1;
  int mptr  = 15;
  int mgidx = 0;
  int stall = 0;
  bit mtevt = 0;
  bit last_xfer;
  bit last_tail;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [15:0] r, int p);
    for (int k = 1; k <= 16; k++)
      if (r[(p + k) % 16]) return (p + k) % 16;
    return -1;
  endfunction

  task automatic cycle(input logic [15:0] r, input logic [15:0] v,
                       input logic [15:0] l, input logic o,
                       input logic do_rst);
    logic [15:0] eg;
    int w;
    req = r;
    flit_valid = v;
    flit_last = l;
    out_ready = o;
    rst = do_rst;
    #1;
    last_xfer = (owner >= 0) && v[owner] && o;
    last_tail = last_xfer && l[owner];
    check("xfer", 32'(xfer), 32'(last_xfer));
    mtevt = 0;
    if (do_rst) begin
      owner = -1;
      mptr = 15;
      mgidx = 0;
      stall = 0;
    end else if (owner < 0) begin
      w = pick(r, mptr);
      if (w >= 0) begin
        owner = w;
        mptr = w;
        mgidx = w;
        stall = 0;
      end
    end else if (last_tail) begin
      owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (stall == TB_TIMEOUT) begin
        owner = -1;
        mtevt = 1;
      end else begin
        stall = last_xfer ? 0 : stall + 1;
      end
`endif
    end
    @(posedge clk);
    #1;
    eg = (owner < 0) ? 16'h0 : (16'h1 << owner);
    check("grant", 32'(grant), 32'(eg));
    check("grant_idx", 32'(grant_idx), 32'(mgidx));
    check("busy", 32'(busy), 32'(owner >= 0));
    check("timeout_evt", 32'(timeout_evt), 32'(mtevt));
  endtask

  task automatic do_reset();
    cycle(16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
  endtask

  int grants[$];
  int nflits;
  int npulse;
  bit was_idle;
  bit saw_tevt;
  logic [15:0] lst;

  initial begin
    rst = 1'b1;
    req = '0;
    flit_valid = '0;
    flit_last = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_idx", 32'(grant_idx), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_tevt", 32'(timeout_evt), 32'h0);

    cycle(16'h0001, 16'h0, 16'h0, 1'b0, 1'b0);
    check("first_grant", 32'(grant), 32'h0001);
    check("first_busy", 32'(busy), 32'h1);

    // round robin over 0,2,15 with 3-flit packets
    do_reset();
    nflits = 0;
    for (int c = 0; c < 16; c++) begin
      was_idle = (owner < 0);
      lst = (nflits == 2) ? 16'hFFFF : 16'h0;
      cycle(16'h8005, 16'hFFFF, lst, 1'b1, 1'b0);
      if (last_tail) nflits = 0;
      else if (last_xfer) nflits++;
      if (was_idle && owner >= 0) grants.push_back(owner);
    end
    check("rr_count", 32'(grants.size()), 32'd4);
    if (grants.size() >= 4) begin
      check("rr0", 32'(grants[0]), 32'd0);
      check("rr1", 32'(grants[1]), 32'd2);
      check("rr2", 32'(grants[2]), 32'd15);
      check("rr3", 32'(grants[3]), 32'd0);
    end

    // stalled downstream on input 3
    do_reset();
    cycle(16'h0008, 16'h0, 16'h0, 1'b0, 1'b0);
    check("in3_grant", 32'(grant), 32'h0008);
    nflits = 0;
    npulse = 0;
    for (int c = 0; c < 5; c++) begin
      lst = (nflits == 2) ? 16'h0008 : 16'h0;
      cycle(16'h0, 16'h0008, lst, (c % 2) == 0, 1'b0);
      if (last_xfer) begin
        nflits++;
        npulse++;
      end
    end
    check("in3_pulses", 32'(npulse), 32'd3);
    check("in3_release", 32'(grant), 32'h0);

    // foreign req/last ignored while holding input 5
    do_reset();
    cycle(16'h0020, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++)
      cycle(16'hFFFF, 16'hFFFF, 16'h0040, 1'b1, 1'b0);
    check("in5_hold", 32'(grant), 32'h0020);
    cycle(16'hFFFF, 16'hFFFF, 16'h0020, 1'b1, 1'b0);
    check("in5_release", 32'(grant), 32'h0);

    // reset mid-packet
    cycle(16'h0100, 16'h0, 16'h0, 1'b0, 1'b0);
    cycle(16'h0100, 16'h0100, 16'h0, 1'b1, 1'b0);
    do_reset();
    check("midrst_busy", 32'(busy), 32'h0);
    cycle(16'h8001, 16'h0, 16'h0, 1'b0, 1'b0);
    check("post_rst_grant", 32'(grant), 32'h0001);

    // stalled hold on input 7
    do_reset();
    cycle(16'h0080, 16'h0, 16'h0, 1'b0, 1'b0);
    saw_tevt = 0;
    for (int c = 0; c < 100; c++) begin
      cycle(16'h0080, 16'h0, 16'h0, 1'b1, 1'b0);
      if (c == TB_TIMEOUT) saw_tevt = timeout_evt;
      if (c == TB_TIMEOUT) break;
    end
`ifdef ARB_TIMEOUT_EN
    check("tevt_pulse", 32'(saw_tevt), 32'h1);
`else
    for (int c = 0; c < 95; c++)
      cycle(16'h0080, 16'h0, 16'h0, 1'b1, 1'b0);
    check("no_timeout", 32'(grant), 32'h0080);
`endif

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(3) == 0) r = '0;
      cycle(r, 16'($urandom | $urandom), 16'($urandom & $urandom),
            $urandom_range(3) != 0, $urandom_range(99) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
# output_port_arbiter

Per-output-port arbiter for the 16x16 crossbar router. It shares one output port among the 16 input ports using round-robin selection. A grant is held for a whole packet, from its first flit to its tail flag. The block drives the crosspoint select and this port's bit of the 16-bit busy vector used by the input-side output-busy lookup.

## Interface
Parameters:
- N_IN, 16, number of requesting input ports (fixed at 16; the index width is 4).
- TIMEOUT, 64, stall-cycle limit before a held grant is forcibly released (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  req[i]=1 when input i has a head flit addressed to this output; level-sensitive.
- flit_valid  input  16  input i presents a valid flit this cycle.
- flit_last  input  16  the flit presented by input i is the packet tail; qualified by flit_valid[i].
- out_ready  input  1  downstream accepts a flit this cycle.
- grant  output  16  one-hot or zero; registered crosspoint select.
- grant_idx  output  4  binary index of the granted input; holds its last value when grant=0.
- busy  output  1  1 while a packet owns the port; equals |grant.
- xfer  output  1  combinational; |(grant & flit_valid) & out_ready.
- timeout_evt  output  1  one-cycle pulse when a grant is forcibly released.

## Operation
- States: IDLE and HOLD.
- IDLE:
  - If req≠0, pick the winner: the first set req bit searching upward from ptr+1, wrapping 15→0.
  - On the next edge, set grant[winner]=1, grant_idx=winner, ptr=winner, and go to HOLD.
  - If req=0, stay in IDLE.
- HOLD:
  - A transfer occurs in a cycle where grant[g]&flit_valid[g]&out_ready is true.
  - A transfer with flit_last[g]=1 is the tail. On the next edge, grant=0 and the state returns to IDLE.
  - While in HOLD, all req bits are ignored, including the granted input's own req. Deasserting req does not release the grant; only the tail flit or a timeout does.
- Valid and last bits on inputs that are not granted are ignored.
- The round-robin pointer advances only when a grant is issued. An input that has just been served is lowest priority in the next arbitration.
- A one-flit packet (head = tail) is granted, transfers once, and is released. Grant lasts at least 1 cycle.
- Reset mid-packet drops the grant immediately at the reset edge; no tail is required.

## Timing
- Reset values: state=IDLE, grant=0, grant_idx=0, busy=0, timeout_evt=0, ptr=15, so input 0 wins first.
- Arbitration latency: req sampled in IDLE at cycle n → grant valid in cycle n+1.
- Release: tail transfer in cycle m → grant=0 in m+1. Re-arbitration happens in m+1 and the new grant appears in m+2. There is a mandatory one-cycle gap between packets.
- grant, grant_idx, busy and timeout_evt are all registered. xfer is combinational from the current-cycle inputs.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A stall counter (width clog2(TIMEOUT+1)) clears on entering HOLD and on every transfer. It increments on every HOLD cycle without a transfer.
  - When the counter reaches TIMEOUT, the next edge sets grant=0, enters IDLE and pulses timeout_evt for 1 cycle. ptr keeps its value.
  - A tail transfer in the same cycle takes precedence; no timeout_evt is generated.
- ARB_TIMEOUT_EN undefined:
  - No counter is built and timeout_evt is tied to 0.
  - HOLD persists until the tail flit or reset.

## Test plan
- Reset, then req=16'h0001 → grant=16'h0001, grant_idx=0 one cycle later; busy=1.
- req=16'h8005 held, each packet 3 flits with out_ready=1 → grants in order input 0, 2, 15, 0. Each grant lasts 3 cycles, followed by 1 idle cycle.
- Granted input 3 with out_ready toggling 1,0,1,0,1 on a 3-flit packet → exactly 3 xfer pulses. Grant drops the cycle after the third xfer.
- During HOLD for input 5, assert req=16'hFFFF and flit_last on input 6 → no change to grant. Release occurs only on input 5's tail.
- rst asserted mid-packet → grant=0 and busy=0 on the next edge. After reset, req=16'h8001 → input 0 is granted first.
- With ARB_TIMEOUT_EN, TIMEOUT=4: grant input 7, then hold flit_valid=0 → timeout_evt pulses after 4 stall cycles and grant=0. Without the macro, the same stimulus holds the grant for 100 cycles.
